// File: rtl/bnn_layer_sequencer_if.sv
// Handshake/phase bus between the BNN layer sequencer and its loader, layers and consumer.
// The sequencer uses the master modport. The datapath and consumer side uses slave.
interface bnn_layer_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             abort;
   logic             load_done;
   logic             l1_done;
   logic             l2_done;
   logic             l3_done;
   logic             ack;
   logic [2:0]       state;
   logic             layer_rst_n;
   logic             busy;
   logic             result_valid;
   logic [CNT_W-1:0] cycles;
   logic             error;

   modport master (
      input  start, abort, load_done, l1_done, l2_done, l3_done, ack,
      output state, layer_rst_n, busy, result_valid, cycles, error
   );

   modport slave (
      output start, abort, load_done, l1_done, l2_done, l3_done, ack,
      input  state, layer_rst_n, busy, result_valid, cycles, error
   );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// Inference phase controller for the BNN pipeline: loader -> layer_one..three -> result.
// Optional per-phase watchdog and error state are enabled by defining WATCHDOG_EN.
module bnn_layer_sequencer #(
   parameter int CNT_W = 16
`ifdef WATCHDOG_EN
   ,parameter int TIMEOUT_CYCLES = 1023
`endif
) (
   input logic                   clk,
   input logic                   rst,
   bnn_layer_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_LOAD    = 3'b001,
      S_LAYER_1 = 3'b010,
      S_LAYER_2 = 3'b011,
      S_LAYER_3 = 3'b100,
      S_DONE    = 3'b101,
      S_ERROR   = 3'b110
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_r;
   state_t           next_state_s;
   logic             in_run_s;
   logic             next_run_s;
   logic             next_armed_s;
   logic             timeout_s;
   logic [CNT_W-1:0] cycles_r;
   logic             layer_rst_n_r;
   logic             busy_r;
   logic             result_valid_r;
   logic             error_r;

   // Current-phase classification used by the counters
   always_comb begin
      in_run_s = 1'b0;
      case (state_r)
         S_LOAD, S_LAYER_1, S_LAYER_2, S_LAYER_3: in_run_s = 1'b1;
         default:                                 in_run_s = 1'b0;
      endcase
   end

`ifdef WATCHDOG_EN
   localparam int             PH_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PH_W-1:0] PH_ONE   = {{(PH_W-1){1'b0}}, 1'b1};
   localparam logic [PH_W-1:0] PH_ZERO  = {PH_W{1'b0}};
   localparam logic [PH_W-1:0] PH_LIMIT = PH_W'(TIMEOUT_CYCLES - 1);

   logic [PH_W-1:0] phase_cnt_r;

   // Phase watchdog counter, restarted whenever the state changes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_cnt_r <= PH_ZERO;
      end else if (next_state_s != state_r) begin
         phase_cnt_r <= PH_ZERO;
      end else if (in_run_s) begin
         phase_cnt_r <= phase_cnt_r + PH_ONE;
      end else begin
         phase_cnt_r <= PH_ZERO;
      end
   end

   // The edge that would make the count reach the limit is the timeout edge
   assign timeout_s = (phase_cnt_r == PH_LIMIT);
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state logic; abort overrides everything and only the active phase's done counts
   always_comb begin
      next_state_s = state_r;
      if (bus.abort) begin
         next_state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE:    if (bus.start)     next_state_s = S_LOAD;
                       else               next_state_s = S_IDLE;
            S_LOAD:    if (bus.load_done) next_state_s = S_LAYER_1;
                       else if (timeout_s) next_state_s = S_ERROR;
                       else               next_state_s = S_LOAD;
            S_LAYER_1: if (bus.l1_done)   next_state_s = S_LAYER_2;
                       else if (timeout_s) next_state_s = S_ERROR;
                       else               next_state_s = S_LAYER_1;
            S_LAYER_2: if (bus.l2_done)   next_state_s = S_LAYER_3;
                       else if (timeout_s) next_state_s = S_ERROR;
                       else               next_state_s = S_LAYER_2;
            S_LAYER_3: if (bus.l3_done)   next_state_s = S_DONE;
                       else if (timeout_s) next_state_s = S_ERROR;
                       else               next_state_s = S_LAYER_3;
            S_DONE:    if (bus.ack)       next_state_s = S_IDLE;
                       else               next_state_s = S_DONE;
            S_ERROR:   if (bus.ack)       next_state_s = S_IDLE;
                       else               next_state_s = S_ERROR;
            default:                      next_state_s = S_IDLE;
         endcase
      end
   end

   // Output decode of the state being entered, so registered outputs track the state
   always_comb begin
      next_run_s   = 1'b0;
      next_armed_s = 1'b0;
      case (next_state_s)
         S_LOAD, S_LAYER_1, S_LAYER_2, S_LAYER_3: begin
            next_run_s   = 1'b1;
            next_armed_s = 1'b1;
         end
         S_DONE: begin
            next_run_s   = 1'b0;
            next_armed_s = 1'b1;
         end
         default: begin
            next_run_s   = 1'b0;
            next_armed_s = 1'b0;
         end
      endcase
   end

   // State and status output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= S_IDLE;
         layer_rst_n_r  <= 1'b0;
         busy_r         <= 1'b0;
         result_valid_r <= 1'b0;
         error_r        <= 1'b0;
      end else begin
         state_r        <= next_state_s;
         layer_rst_n_r  <= next_armed_s;
         busy_r         <= next_run_s;
         result_valid_r <= (next_state_s == S_DONE);
         error_r        <= (next_state_s == S_ERROR);
      end
   end

   // Saturating run-length counter; cleared by an accepted start, frozen by abort
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycles_r <= {CNT_W{1'b0}};
      end else if (bus.abort) begin
         cycles_r <= cycles_r;
      end else if ((state_r == S_IDLE) && bus.start) begin
         cycles_r <= {CNT_W{1'b0}};
      end else if (in_run_s && (cycles_r != CNT_MAX)) begin
         cycles_r <= cycles_r + CNT_ONE;
      end else begin
         cycles_r <= cycles_r;
      end
   end

   assign bus.state        = state_r;
   assign bus.layer_rst_n  = layer_rst_n_r;
   assign bus.busy         = busy_r;
   assign bus.result_valid = result_valid_r;
   assign bus.cycles       = cycles_r;
   assign bus.error        = error_r;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed self-checking bench for bnn_layer_sequencer (watchdog scenarios need WATCHDOG_EN).
module tb_bnn_layer_sequencer;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   bnn_layer_sequencer_if #(.CNT_W(16)) bus ();

`ifdef WATCHDOG_EN
   bnn_layer_sequencer #(.CNT_W(16), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));
`else
   bnn_layer_sequencer #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.master));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start = 1'b0; bus.abort = 1'b0; bus.ack = 1'b0; bus.load_done = 1'b0;
      bus.l1_done = 1'b0; bus.l2_done = 1'b0; bus.l3_done = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({bus.state, bus.layer_rst_n, bus.busy, bus.result_valid, bus.error} !== 7'b0000000) begin
         tests_failed++;
         $display("FAIL reset_outputs: got state=%b lrn=%b busy=%b rv=%b err=%b, want all 0",
                  bus.state, bus.layer_rst_n, bus.busy, bus.result_valid, bus.error);
      end
      tests_run++;
      if (bus.cycles !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_cycles: got %0d want 0", bus.cycles);
      end
      step();
      rst = 1'b0;
      step();
      tests_run++;
      if (bus.state !== 3'b000) begin
         tests_failed++;
         $display("FAIL idle_after_reset: got %b want 000", bus.state);
      end
   endtask

   task automatic test_async_reset();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      bus.load_done = 1'b1; bus.l1_done = 1'b1;
      step(); step();
      tests_run++;
      if (bus.state !== 3'b011) begin
         tests_failed++;
         $display("FAIL areset_setup: got %b want 011", bus.state);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({bus.state, bus.layer_rst_n, bus.busy} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL areset_mid_run: got state=%b lrn=%b busy=%b want 000/0/0",
                  bus.state, bus.layer_rst_n, bus.busy);
      end
      clear_inputs();
      #1 rst = 1'b0;
      step();
   endtask

   task automatic test_normal_run();
      logic [2:0] exp_state;
      clear_inputs();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      tests_run++;
      if ({bus.state, bus.layer_rst_n, bus.busy} !== 5'b00111 || bus.cycles !== 16'd0) begin
         tests_failed++;
         $display("FAIL run_enter_load: got state=%b lrn=%b busy=%b cycles=%0d want 001/1/1/0",
                  bus.state, bus.layer_rst_n, bus.busy, bus.cycles);
      end
      for (int k = 1; k <= 40; k++) begin
         if (k == 5)  bus.load_done = 1'b1;
         if (k == 20) bus.l1_done = 1'b1;
         if (k == 30) bus.l2_done = 1'b1;
         if (k == 40) bus.l3_done = 1'b1;
         step();
         if (k < 5)       exp_state = 3'b001;
         else if (k < 20) exp_state = 3'b010;
         else if (k < 30) exp_state = 3'b011;
         else if (k < 40) exp_state = 3'b100;
         else             exp_state = 3'b101;
         tests_run++;
         if (bus.state !== exp_state) begin
            tests_failed++;
            $display("FAIL run_state_k%0d: got %b want %b", k, bus.state, exp_state);
         end
      end
      tests_run++;
      if ({bus.result_valid, bus.busy, bus.layer_rst_n} !== 3'b101 || bus.cycles !== 16'd40) begin
         tests_failed++;
         $display("FAIL run_done: got rv=%b busy=%b lrn=%b cycles=%0d want 1/0/1/40",
                  bus.result_valid, bus.busy, bus.layer_rst_n, bus.cycles);
      end
      step();
      tests_run++;
      if (bus.state !== 3'b101 || bus.cycles !== 16'd40) begin
         tests_failed++;
         $display("FAIL run_done_hold: got state=%b cycles=%0d want 101/40", bus.state, bus.cycles);
      end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      tests_run++;
      if ({bus.state, bus.layer_rst_n, bus.result_valid} !== 5'b00000 || bus.cycles !== 16'd40) begin
         tests_failed++;
         $display("FAIL run_ack: got state=%b lrn=%b rv=%b cycles=%0d want 000/0/0/40",
                  bus.state, bus.layer_rst_n, bus.result_valid, bus.cycles);
      end
      clear_inputs();
   endtask

   task automatic test_no_skip_and_start_ack();
      clear_inputs();
      bus.l2_done = 1'b1; bus.l3_done = 1'b1;
      bus.start = 1'b1; step(); bus.start = 1'b0;
      bus.load_done = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         step();
         tests_run++;
         if (bus.state !== 3'b010) begin
            tests_failed++;
            $display("FAIL noskip_hold_%0d: got %b want 010", k, bus.state);
         end
      end
      bus.l1_done = 1'b1;
      step();
      tests_run++;
      if (bus.state !== 3'b011) begin
         tests_failed++;
         $display("FAIL noskip_l2: got %b want 011", bus.state);
      end
      step();
      tests_run++;
      if (bus.state !== 3'b100) begin
         tests_failed++;
         $display("FAIL noskip_l3: got %b want 100", bus.state);
      end
      step();
      tests_run++;
      if (bus.state !== 3'b101 || bus.cycles !== 16'd7) begin
         tests_failed++;
         $display("FAIL noskip_done: got state=%b cycles=%0d want 101/7", bus.state, bus.cycles);
      end
      bus.start = 1'b1; bus.ack = 1'b1; step(); bus.start = 1'b0; bus.ack = 1'b0;
      tests_run++;
      if (bus.state !== 3'b000 || bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL start_ack_idle: got state=%b busy=%b want 000/0", bus.state, bus.busy);
      end
      step();
      tests_run++;
      if (bus.state !== 3'b000) begin
         tests_failed++;
         $display("FAIL start_ack_dropped: got %b want 000", bus.state);
      end
      clear_inputs();
   endtask

   task automatic test_abort();
      clear_inputs();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      bus.load_done = 1'b1; bus.l1_done = 1'b1; bus.l2_done = 1'b1;
      step(); step(); step();
      tests_run++;
      if (bus.state !== 3'b100 || bus.cycles !== 16'd3) begin
         tests_failed++;
         $display("FAIL abort_setup: got state=%b cycles=%0d want 100/3", bus.state, bus.cycles);
      end
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      tests_run++;
      if ({bus.state, bus.layer_rst_n, bus.result_valid} !== 5'b00000 || bus.cycles !== 16'd3) begin
         tests_failed++;
         $display("FAIL abort_l3: got state=%b lrn=%b rv=%b cycles=%0d want 000/0/0/3",
                  bus.state, bus.layer_rst_n, bus.result_valid, bus.cycles);
      end
      clear_inputs();
   endtask

`ifndef WATCHDOG_EN
   task automatic test_saturation();
      clear_inputs();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      repeat (65540) step();
      tests_run++;
      if (bus.cycles !== 16'hFFFF || bus.state !== 3'b001 || bus.error !== 1'b0) begin
         tests_failed++;
         $display("FAIL saturate: got cycles=%h state=%b err=%b want ffff/001/0",
                  bus.cycles, bus.state, bus.error);
      end
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      clear_inputs();
   endtask
`else
   task automatic test_watchdog();
      clear_inputs();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      bus.load_done = 1'b1; step();
      for (int k = 1; k <= 8; k++) begin
         step();
         tests_run++;
         if (k < 8 && bus.state !== 3'b010) begin
            tests_failed++;
            $display("FAIL wdog_wait_%0d: got %b want 010", k, bus.state);
         end else if (k == 8 && {bus.state, bus.error, bus.layer_rst_n, bus.busy} !== 6'b110100) begin
            tests_failed++;
            $display("FAIL wdog_error: got state=%b err=%b lrn=%b busy=%b want 110/1/0/0",
                     bus.state, bus.error, bus.layer_rst_n, bus.busy);
         end
      end
      bus.ack = 1'b1; step(); bus.ack = 1'b0;
      tests_run++;
      if (bus.state !== 3'b000 || bus.error !== 1'b0) begin
         tests_failed++;
         $display("FAIL wdog_ack: got state=%b err=%b want 000/0", bus.state, bus.error);
      end
      clear_inputs();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      bus.load_done = 1'b1; step();
      repeat (7) step();
      bus.l1_done = 1'b1; step();
      tests_run++;
      if (bus.state !== 3'b011 || bus.error !== 1'b0) begin
         tests_failed++;
         $display("FAIL wdog_done_wins: got state=%b err=%b want 011/0", bus.state, bus.error);
      end
      bus.abort = 1'b1; step();
      clear_inputs();
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_async_reset();
`ifndef WATCHDOG_EN
      test_normal_run();
`endif
      test_no_skip_and_start_ack();
      test_abort();
`ifndef WATCHDOG_EN
      test_saturation();
`else
      test_watchdog();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
